// File: rtl/dc_cic_decimator.sv
// Second-order CIC decimator (R = DECIM) with a 2-entry FWFT output FIFO and sticky overflow.
// Optional peak-magnitude tracker enabled by defining DC_CIC_PEAK_EN.
`timescale 1ns/1ps
module dc_cic_decimator #(
  parameter int unsigned DECIM = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             CLK_24M,
  input  logic             reset,
  input  logic             enable_3M,
  input  logic [8:0]       i_data,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready,
  input  logic             clr_ovf,
`ifdef DC_CIC_PEAK_EN
  input  logic             clr_peak,
  output logic [OUT_W-2:0] peak,
`endif
  output logic             ovf
);

  localparam int unsigned PW = $clog2(DECIM);
  localparam int unsigned W  = 9 + 2 * PW;
  localparam logic [PW-1:0] PhaseLast = PW'(DECIM - 1);

  if (DECIM < 2 || DECIM > 64 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("DECIM must be a power of two in 2..64");
  end
  if (OUT_W < W) begin : g_bad_out_w
    $error("OUT_W must be at least 9 + 2*log2(DECIM)");
  end

  logic [W-1:0]  i1_q, i2_q, x_q, d1_q, d2_q, y_q;
  logic [W-1:0]  mem_q [2];
  logic          x_vld_q, y_vld_q;
  logic [PW-1:0] phase_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic          ovf_q;

  logic [W-1:0]  in_ext, i1_next, i2_next, c1, c2, head;
  logic          dec, push, pop, push_ok, drop, wr_ptr;
  logic [1:0]    cnt_d;

  always_comb begin
    in_ext  = W'($signed(i_data));
    i1_next = i1_q + in_ext;
    i2_next = i2_q + i1_next;
    c1      = x_q - d1_q;
    c2      = c1 - d2_q;
    dec     = enable_3M && (phase_q == PhaseLast);
    push    = y_vld_q;
    pop     = o_valid && o_ready;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    push_ok = push && ((cnt_q != 2'd2) || pop);
    drop    = push && !push_ok;
    wr_ptr  = rd_q ^ cnt_q[0];
    cnt_d   = cnt_q + 2'(push_ok) - 2'(pop);
    head    = mem_q[rd_q];
    o_valid = (cnt_q != 2'd0);
    o_data  = o_valid ? OUT_W'($signed(head)) : '0;
    ovf     = ovf_q;
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      i1_q     <= '0;
      i2_q     <= '0;
      x_q      <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      y_q      <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      x_vld_q  <= 1'b0;
      y_vld_q  <= 1'b0;
      phase_q  <= '0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (enable_3M) begin
        i1_q    <= i1_next;
        i2_q    <= i2_next;
        phase_q <= phase_q + PW'(1);
      end
      x_vld_q <= dec;
      if (dec) x_q <= i2_next;
      y_vld_q <= x_vld_q;
      if (x_vld_q) begin
        d1_q <= x_q;
        d2_q <= c1;
        y_q  <= c2;
      end
      if (push_ok) mem_q[wr_ptr] <= y_q;
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
      if (drop) ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

`ifdef DC_CIC_PEAK_EN
  localparam logic [W-1:0] MinVal = {1'b1, {(W - 1){1'b0}}};

  logic [W-1:0]     y_neg;
  logic [W-2:0]     mag;
  logic [OUT_W-2:0] peak_base, peak_q;

  always_comb begin
    y_neg     = -y_q;
    // The most negative sample has no positive counterpart; clamp it.
    if (y_q == MinVal)  mag = {(W - 1){1'b1}};
    else if (y_q[W-1])  mag = y_neg[W-2:0];
    else                mag = y_q[W-2:0];
    peak_base = clr_peak ? '0 : peak_q;
    peak      = peak_q;
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
    end else if (push_ok && ((OUT_W - 1)'(mag) > peak_base)) begin
      peak_q <= (OUT_W - 1)'(mag);
    end else begin
      peak_q <= peak_base;
    end
  end
`endif

endmodule

// File: doc/dc_cic_decimator.md
Name: dc_cic_decimator

Overview:
- Second-order CIC decimator directly downstream of the DC-removal filter.
- Consumes the filter's 9-bit signed output at the 3 MHz enable rate and decimates by DECIM.
- Presents wider PCM words to the next stage through a valid/ready interface.
- Contains a 2-entry output buffer, a decimation phase counter and a sticky overflow flag.

Parameters:
- DECIM, 8, decimation ratio; power of two, 2..64.
- OUT_W, 16, output word width; must be >= W, where W = 9 + 2*log2(DECIM). Elaboration error otherwise.

Ports:
- CLK_24M  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable_3M  input  1  one-cycle input-sample strobe.
- i_data  input  9  signed two's-complement sample from the DC-removal filter, valid when enable_3M=1.
- o_data  output  OUT_W  signed decimated sample, sign-extended from W bits.
- o_valid  output  1  o_data holds a sample.
- o_ready  input  1  consumer accepts o_data when o_valid & o_ready.
- clr_ovf  input  1  clears ovf.
- ovf  output  1  sticky: a decimated sample was dropped because the buffer was full.

Behaviour:
- Reset (asynchronous, active-high) clears everything to 0:
  - integrators i1, i2; comb delays d1, d2; phase counter; buffer contents and count.
  - Outputs: o_data=0, o_valid=0, ovf=0.
  - Reset mid-operation discards buffered samples and restarts phase at 0.
- Arithmetic:
  - All internal state is W bits, modulo 2^W.
  - Integrator wrap-around is permitted and required; no saturation.
- Integrators, on each CLK_24M edge with enable_3M=1:
  - i1 <= i1 + sext(i_data).
  - i2 <= i2 + i1_next, where i1_next is the new i1 value in the same cycle.
- Phase counter:
  - Increments on each enable_3M; wraps DECIM-1 -> 0.
  - With enable_3M=0, nothing changes. Gaps between enables are arbitrary.
- Decimation event: enable_3M=1 while phase==DECIM-1.
  - Cycle T: latch x = i2_next into the comb stage.
  - Cycle T+1 (comb register):
    - c1 = x - d1; d1 <= x.
    - c2 = c1 - d2; d2 <= c1.
    - Result y = c2 is pushed into the buffer.
  - o_valid rises at T+2 when the buffer was empty. Latency from the decimating enable edge to o_valid is 2 clocks.
- Output buffer: 2-entry FIFO, first-word fall-through.
  - o_data always shows the head entry. o_data is 0 when the buffer is empty.
  - Pop on o_valid & o_ready.
  - Simultaneous push and pop with count=2 is legal: count stays 2, no drop.
  - Push when count=2 and no pop: sample dropped, ovf <= 1, buffer unchanged.
- ovf:
  - Cleared by clr_ovf=1.
  - If clr_ovf and a new drop occur in the same cycle, ovf=1 (set wins).
- Steady-state DC gain is DECIM^2; constant input k yields k*DECIM^2.

Optional Feature:
- Macro DC_CIC_PEAK_EN.
- Defined:
  - Adds output port peak [OUT_W-2:0]: the largest |y| pushed since the last clear. |−2^(W-1)| saturates to 2^(W-1)-1.
  - Adds input port clr_peak: sets peak to 0.
  - If clr_peak coincides with a push, peak = |y| of that sample.
  - Reset value 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Constant i_data=1, enable_3M every 8th clock, DECIM=8, o_ready=1 -> outputs 36, 64, 64, 64...; each o_valid asserted 2 clocks after every 8th enable.
- Constant i_data=-256, DECIM=8 -> steady-state o_data=0xC000 (-16384); no wrap errors after 1000+ samples, despite integrator wrap.
- o_ready=0 for 3 decimation periods -> first two samples held in order, third dropped, ovf=1. Raise o_ready: two valid words, then empty. Pulse clr_ovf: ovf=0.
- Pop and push in the same cycle with buffer full -> no drop, ovf stays 0, order preserved.
- Assert reset mid-period (phase=5) with 1 buffered sample -> o_valid=0 and o_data=0 immediately. After release, the first output again equals 36 for input=1.
- DC_CIC_PEAK_EN defined, input alternating +255/-255 blocks -> peak tracks the max |y|; clr_peak zeroes it; with macro undefined the bench compiles without the peak ports.
